data_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache; responder side of the core's D-cache port.

---
 rtl/data_cache.sv | 151 +++++++++++++++
 tb/tb_data_cache.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache.
// 4-word blocks, block-wide memory port, stalls the pipeline on misses.
module data_cache #(
  parameter int INDEX_W = 3,
  parameter int ADDR_W  = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              proc_ren,
  input  logic              proc_wen,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]             valid_q, valid_d;
  logic [SETS-1:0]             dirty_q, dirty_d;
  logic [SETS-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [SETS-1:0][127:0]      data_q, data_d;

  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [127:0]      mem_wdata_q, mem_wdata_d;

  logic [INDEX_W-1:0] req_idx;
  logic [1:0]         req_off;
  logic [TAG_W-1:0]   req_tag;
  logic [6:0]         req_bit;
  logic               req;
  logic               hit;

  assign req_off = proc_addr[1:0];
  assign req_idx = proc_addr[INDEX_W+1:2];
  assign req_tag = proc_addr[ADDR_W-1:INDEX_W+2];
  assign req_bit = {req_off, 5'b0};
  assign req     = proc_ren | proc_wen;
  assign hit     = valid_q[req_idx]
                && (tag_q[req_idx] == req_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COMPARE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tags and data need no reset: valid bits gate them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COMPARE: begin
        if (req && !hit) begin
          if (valid_q[req_idx] && dirty_q[req_idx])
            state_d = WRITEBACK;
          else
            state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (mem_ready) state_d = COMPARE;
      end
      default: state_d = COMPARE;
    endcase
  end

  always_comb begin
    proc_stall  = 1'b1;
    proc_rdata  = '0;
    mem_ren_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_q == COMPARE) begin
      proc_stall = req && !hit;
      if (proc_ren && !proc_wen && hit)
        proc_rdata = data_q[req_idx][req_bit +: 32];
    end
    // Memory outputs follow the state being entered.
    if (state_d == WRITEBACK) begin
      mem_wen_d   = 1'b1;
      mem_addr_d  = {tag_q[req_idx], req_idx};
      mem_wdata_d = data_q[req_idx];
    end else if (state_d == ALLOCATE) begin
      mem_ren_d  = 1'b1;
      mem_addr_d = {req_tag, req_idx};
    end
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (state_q == COMPARE && proc_wen && hit) begin
      data_d[req_idx][req_bit +: 32] = proc_wdata;
      dirty_d[req_idx] = 1'b1;
    end
    if (state_q == ALLOCATE && mem_ready) begin
      data_d[req_idx]  = mem_rdata;
      tag_d[req_idx]   = req_tag;
      valid_d[req_idx] = 1'b1;
      dirty_d[req_idx] = 1'b0;
    end
  end

  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: hit vector table plus
// hand-written miss, writeback, reset and wrap sequences.
module tb_data_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_ren, proc_wen;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata, proc_rdata;
  logic         proc_stall;
  logic         mem_ren, mem_wen;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] A = 32'hAAAA0000;
  localparam logic [31:0] B = 32'hBBBB1111;
  localparam logic [31:0] C = 32'hCCCC2222;
  localparam logic [31:0] D = 32'hDDDD3333;
  localparam logic [31:0] W0 = 32'h0000F000;
  localparam logic [31:0] W1 = 32'h0000F001;
  localparam logic [31:0] W2 = 32'h0000F002;
  localparam logic [31:0] W3 = 32'h0000F003;

  always #5 clk = ~clk;

  data_cache dut (
    .clk        (clk),
    .rst        (rst),
    .proc_ren   (proc_ren),
    .proc_wen   (proc_wen),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    int          phase;
    logic        ren;
    logic        wen;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int ph, input logic r,
                     input logic w, input logic [29:0] a,
                     input logic [31:0] wd, input logic st,
                     input logic [31:0] rd, input string nm);
    vec_t v;
    v.phase = ph; v.ren = r; v.wen = w; v.addr = a;
    v.wdata = wd; v.stall = st; v.rdata = rd; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input int ph);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == ph) begin
        @(negedge clk);
        proc_ren   = vecs[i].ren;
        proc_wen   = vecs[i].wen;
        proc_addr  = vecs[i].addr;
        proc_wdata = vecs[i].wdata;
        #1;
        chk({vecs[i].name, "_stall"}, 128'(proc_stall),
            128'(vecs[i].stall));
        chk({vecs[i].name, "_rdata"}, 128'(proc_rdata),
            128'(vecs[i].rdata));
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    proc_ren = 1'b0;
    proc_wen = 1'b0;
  endtask

  task automatic request(input string nm, input logic r,
                         input logic w, input logic [29:0] a,
                         input logic [31:0] wd);
    @(negedge clk);
    proc_ren = r; proc_wen = w;
    proc_addr = a; proc_wdata = wd;
    #1;
    chk({nm, "_stall0"}, 128'(proc_stall), 128'(1));
    chk({nm, "_rdata0"}, 128'(proc_rdata), 128'(0));
  endtask

  task automatic xfer(input string nm, input bit is_wr,
                      input logic [27:0] a,
                      input logic [127:0] wexp,
                      input logic [127:0] rd, input int lat);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk({nm, "_ren"}, 128'(mem_ren), 128'(!is_wr));
    chk({nm, "_wen"}, 128'(mem_wen), 128'(is_wr));
    chk({nm, "_addr"}, 128'(mem_addr), 128'(a));
    chk({nm, "_stall"}, 128'(proc_stall), 128'(1));
    if (is_wr) chk({nm, "_wdata"}, mem_wdata, wexp);
    repeat (lat - 1) @(negedge clk);
    mem_rdata = rd;
    mem_ready = 1'b1;
  endtask

  task automatic done(input string nm, input logic [31:0] rd);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk({nm, "_stall"}, 128'(proc_stall), 128'(0));
    chk({nm, "_rdata"}, 128'(proc_rdata), 128'(rd));
    chk({nm, "_ren_off"}, 128'(mem_ren), 128'(0));
    chk({nm, "_wen_off"}, 128'(mem_wen), 128'(0));
  endtask

  initial begin
    add(1, 1, 0, 30'h13, 0, 0, D, "rd13");
    add(1, 1, 0, 30'h12, 0, 0, C, "rd12");
    add(1, 0, 1, 30'h11, 32'hDEADBEEF, 0, 0, "wr11");
    add(1, 1, 0, 30'h11, 0, 0, 32'hDEADBEEF, "rd11");
    add(1, 0, 0, 30'h11, 0, 0, 0, "idle");
    add(1, 1, 0, 30'h10, 0, 0, A, "rd10");
    add(2, 1, 0, 30'h07, 0, 0, 32'h12345678, "rd07");
    add(2, 1, 0, 30'h06, 0, 0, W2, "rd06");
    add(2, 1, 0, 30'h04, 0, 0, W0, "rd04");
    add(3, 1, 1, 30'h11, 32'h5, 0, 0, "rw11");
    add(3, 1, 0, 30'h11, 0, 0, 32'h5, "rd11b");
    add(3, 1, 0, 30'h10, 0, 0, A, "rd10b");
    add(3, 1, 0, 30'h13, 0, 0, D, "rd13b");

    rst = 1'b1;
    proc_ren = 0; proc_wen = 0;
    proc_addr = '0; proc_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", 128'(proc_stall), 0);
    chk("rst_rdata", 128'(proc_rdata), 0);
    chk("rst_ren", 128'(mem_ren), 0);
    chk("rst_wen", 128'(mem_wen), 0);
    chk("rst_addr", 128'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);

    // cold read miss, clean allocate
    request("tc1", 1, 0, 30'h10, 0);
    chk("tc1_ren_reg", 128'(mem_ren), 0);
    xfer("tc1", 0, 28'h4, 0, {D, C, B, A}, 5);
    done("tc1", A);
    apply(1);

    // stray mem_ready while idle
    @(negedge clk);
    proc_ren = 0; proc_wen = 0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("stray_ren", 128'(mem_ren), 0);
    chk("stray_wen", 128'(mem_wen), 0);
    chk("stray_stall", 128'(proc_stall), 0);

    // dirty conflict: writeback then allocate
    request("tc3", 1, 0, 30'h31, 0);
    xfer("tc3wb", 1, 28'h4, {D, C, 32'hDEADBEEF, A}, 0, 2);
    xfer("tc3al", 0, 28'hC, 0,
         {32'h44444444, 32'h33333333,
          32'h22222222, 32'h11111111}, 3);
    done("tc3", 32'h22222222);

    // write miss to clean set
    request("tc4", 0, 1, 30'h07, 32'h12345678);
    xfer("tc4al", 0, 28'h1, 0, {W3, W2, W1, W0}, 2);
    done("tc4", 0);
    apply(2);
    request("tc4b", 1, 0, 30'h27, 0);
    xfer("tc4wb", 1, 28'h1, {32'h12345678, W2, W1, W0}, 0, 1);
    xfer("tc4al2", 0, 28'h9, 0,
         {32'h99990003, 32'h99990002,
          32'h99990001, 32'h99990000}, 1);
    done("tc4b", 32'h99990003);

    // reset mid-allocate
    request("tc5a", 1, 0, 30'h10, 0);
    @(negedge clk);
    #1;
    chk("tc5_ren_on", 128'(mem_ren), 1);
    chk("tc5_addr", 128'(mem_addr), 128'h4);
    @(negedge clk);
    rst = 1'b1;
    proc_ren = 0;
    @(negedge clk);
    rst = 1'b0;
    mem_rdata = '1;
    mem_ready = 1'b1;
    #1;
    chk("tc5_ren_rst", 128'(mem_ren), 0);
    chk("tc5_stall_rst", 128'(proc_stall), 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("tc5_ren_late", 128'(mem_ren), 0);
    chk("tc5_wen_late", 128'(mem_wen), 0);
    request("tc5b", 1, 0, 30'h10, 0);
    xfer("tc5b", 0, 28'h4, 0, {D, C, B, A}, 2);
    done("tc5b", A);
    request("tc5c", 1, 0, 30'h27, 0);
    xfer("tc5c", 0, 28'h9, 0, {W3, W2, W1, W0}, 1);
    done("tc5c", W3);

    // ren and wen together act as a write
    apply(3);

    // top address: set 7, word 3, all-ones tag
    request("wrap", 1, 0, 30'h3FFFFFFF, 0);
    xfer("wrap", 0, 28'hFFFFFFF, 0,
         {32'h77770003, 32'h77770002,
          32'h77770001, 32'h77770000}, 2);
    done("wrap", 32'h77770003);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
